// File: rtl/rmgmt_arb_pkg.sv
// Shared types for the RISC-MGMT data-memory arbiter: FSM state and the
// request record used both for requester inputs and the granted-request latch.
package rmgmt_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CORE      = 3'd1,
    EXT       = 3'd2,
    DONE_CORE = 3'd3,
    DONE_EXT  = 3'd4
  } rmgmt_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        ren;
    logic        wen;
  } mem_req_t;

  // A request strobing both ren and wen is issued as a write.
  function automatic mem_req_t norm_dir(input mem_req_t r);
    mem_req_t o;
    o     = r;
    o.ren = r.ren & ~r.wen;
    return o;
  endfunction

endpackage

// File: rtl/rmgmt_starve_counter.sv
// Saturating count of core grants made while the extension waits; at_limit
// forces the next grant to the extension. Zero-latency flag from registered count.
module rmgmt_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [W-1:0] LIMIT = W'(STARVE_LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rmgmt_mem_arbiter.sv
// Shares the data-memory bus between core load/store and RISC-MGMT requests.
// Two-cycle minimum latency; requesters hold until their busy drops.
module rmgmt_mem_arbiter
  import rmgmt_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ext_req_mem,
  input  logic        ext_ren,
  input  logic        ext_wen,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [3:0]  ext_byte_en,
  input  logic        ext_abort,
  output logic [31:0] ext_rdata,
  output logic        ext_busy,
  input  logic        core_ren,
  input  logic        core_wen,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_byte_en,
  output logic [31:0] core_rdata,
  output logic        core_busy,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [3:0]  bus_byte_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic        proto_err
);

  rmgmt_arb_state_t state_q, state_d;
  mem_req_t         lat_q, lat_d;
  mem_req_t         core_req, ext_req;
  logic [31:0]      core_rdata_q, core_rdata_d;
  logic [31:0]      ext_rdata_q, ext_rdata_d;
  logic             perr_q, perr_d;
  logic             abort_q, abort_d;
  logic             core_act, ext_act, grant, ext_win, at_limit, xfer;

  assign core_req = '{addr: core_addr, wdata: core_wdata, byte_en: core_byte_en,
                      ren: core_ren, wen: core_wen};
  assign ext_req  = '{addr: ext_addr, wdata: ext_wdata, byte_en: ext_byte_en,
                      ren: ext_ren, wen: ext_wen};

  assign core_act = core_ren | core_wen;
  assign ext_act  = ext_req_mem & (ext_ren | ext_wen) & ~ext_abort;
  assign grant    = (state_q == IDLE) & (core_act | ext_act);
  assign ext_win  = ext_act & (~core_act | at_limit);

  rmgmt_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .inc_i     (grant & ~ext_win & ext_act),
    .clr_i     (~ext_act | (grant & ext_win)),
    .at_limit_o(at_limit)
  );

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    core_rdata_d = core_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    abort_d      = abort_q;
    perr_d       = perr_q | (core_ren & core_wen) | (ext_req_mem & ext_ren & ext_wen);
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (grant) begin
          if (ext_win) begin
            lat_d   = norm_dir(ext_req);
            state_d = EXT;
          end else begin
            lat_d   = norm_dir(core_req);
            state_d = CORE;
          end
        end
      end
      CORE: begin
        if (!bus_busy) begin
          core_rdata_d = bus_rdata;
          state_d      = DONE_CORE;
        end
      end
      EXT: begin
        // An abort seen at any point of the transfer suppresses the load data.
        abort_d = abort_q | ext_abort;
        if (!bus_busy) begin
          if (!(abort_q | ext_abort)) begin
            ext_rdata_d = bus_rdata;
          end
          state_d = DONE_EXT;
        end
      end
      DONE_CORE, DONE_EXT: state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
      perr_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      core_rdata_q <= core_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      perr_q       <= perr_d;
      abort_q      <= abort_d;
    end
  end

  assign xfer        = (state_q == CORE) | (state_q == EXT);
  assign bus_ren     = xfer & lat_q.ren;
  assign bus_wen     = xfer & lat_q.wen;
  assign bus_addr    = lat_q.addr;
  assign bus_wdata   = lat_q.wdata;
  assign bus_byte_en = lat_q.byte_en;
  assign core_rdata  = core_rdata_q;
  assign ext_rdata   = ext_rdata_q;
  assign proto_err   = perr_q;
  assign core_busy   = core_act & (state_q != DONE_CORE);
  assign ext_busy    = ext_act & (state_q != DONE_EXT);

endmodule

// File: tb/tb_rmgmt_mem_arbiter.sv
// Self-checking bench: transaction-level model plus directed scenarios and random traffic.
module tb_rmgmt_mem_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ext_req_mem, ext_ren, ext_wen, ext_abort;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [3:0]  ext_byte_en;
  logic        ext_busy;
  logic        core_ren, core_wen, core_busy;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_byte_en;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ren, bus_wen, bus_busy, proto_err;
  logic [3:0]  bus_byte_en;

  always #5 CLK = ~CLK;

  rmgmt_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .ext_req_mem(ext_req_mem), .ext_ren(ext_ren), .ext_wen(ext_wen),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_byte_en(ext_byte_en),
    .ext_abort(ext_abort), .ext_rdata(ext_rdata), .ext_busy(ext_busy),
    .core_ren(core_ren), .core_wen(core_wen), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_byte_en(core_byte_en),
    .core_rdata(core_rdata), .core_busy(core_busy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ren(bus_ren), .bus_wen(bus_wen),
    .bus_byte_en(bus_byte_en), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
    .proto_err(proto_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for a grant, 1 = bus transfer, 2 = one-cycle completion.
  int          m_phase   = 0;
  bit          m_own_ext = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_crd = '0, m_erd = '0;
  logic [3:0]  m_be = '0;
  bit          m_ren = 1'b0, m_wen = 1'b0, m_perr = 1'b0, m_abort = 1'b0;
  int          m_starve = 0;

  function automatic bit ext_active();
    return ext_req_mem && (ext_ren || ext_wen) && !ext_abort;
  endfunction

  task automatic model_step();
    bit ca, ea, ew;
    ca = core_ren || core_wen;
    ea = ext_active();
    if (!nRST) begin
      m_phase = 0; m_own_ext = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
      m_ren = 1'b0; m_wen = 1'b0; m_crd = '0; m_erd = '0; m_perr = 1'b0;
      m_abort = 1'b0; m_starve = 0;
      return;
    end
    if ((core_ren && core_wen) || (ext_req_mem && ext_ren && ext_wen)) m_perr = 1'b1;
    if (m_phase == 0) begin
      m_abort = 1'b0;
      if (ca || ea) begin
        ew = ea && (!ca || m_starve == LIMIT);
        if (ew) begin
          m_addr = ext_addr; m_wdata = ext_wdata; m_be = ext_byte_en;
          m_wen = ext_wen; m_ren = ext_ren && !ext_wen;
          m_starve = 0;
        end else begin
          m_addr = core_addr; m_wdata = core_wdata; m_be = core_byte_en;
          m_wen = core_wen; m_ren = core_ren && !core_wen;
          m_starve = ea ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end
        m_own_ext = ew;
        m_phase   = 1;
      end else begin
        m_starve = 0;
      end
    end else begin
      if (!ea) m_starve = 0;
      if (m_phase == 1) begin
        if (m_own_ext && ext_abort) m_abort = 1'b1;
        if (!bus_busy) begin
          if (!m_own_ext) m_crd = bus_rdata;
          else if (!m_abort) m_erd = bus_rdata;
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("m_bus_ren", 32'(bus_ren), 32'(m_phase == 1 && m_ren));
      chk("m_bus_wen", 32'(bus_wen), 32'(m_phase == 1 && m_wen));
      chk("m_bus_addr", bus_addr, m_addr);
      chk("m_bus_wdata", bus_wdata, m_wdata);
      chk("m_bus_be", 32'(bus_byte_en), 32'(m_be));
      chk("m_core_rdata", core_rdata, m_crd);
      chk("m_ext_rdata", ext_rdata, m_erd);
      chk("m_proto_err", 32'(proto_err), 32'(m_perr));
      chk("m_core_busy", 32'(core_busy),
          32'((core_ren || core_wen) && !(m_phase == 2 && !m_own_ext)));
      chk("m_ext_busy", 32'(ext_busy), 32'(ext_active() && !(m_phase == 2 && m_own_ext)));
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  logic [31:0] ga [8];
  int          ng, sc, ncore, r;

  initial begin
    nRST = 1'b0;
    ext_req_mem = 0; ext_ren = 0; ext_wen = 0; ext_abort = 0;
    ext_addr = '0; ext_wdata = '0; ext_byte_en = '0;
    core_ren = 0; core_wen = 0; core_addr = '0; core_wdata = '0; core_byte_en = '0;
    bus_rdata = '0; bus_busy = 1'b1;
    tick(); tick();
    chk_on = 1'b1;
    @(negedge CLK);
    chk("rst_bus_ren", 32'(bus_ren), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_ext_rdata", ext_rdata, 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    tick();
    nRST = 1'b1;

    // Core-only read, bus ready on first strobe cycle.
    core_ren = 1; core_addr = 32'h100; core_byte_en = 4'hF;
    bus_busy = 0; bus_rdata = 32'hDEADBEEF;
    @(negedge CLK); chk("rd_busy_c0", 32'(core_busy), 32'd1);
    tick();
    @(negedge CLK); chk("rd_ren_c1", 32'(bus_ren), 32'd1); chk("rd_addr_c1", bus_addr, 32'h100);
    tick();
    @(negedge CLK); chk("rd_busy_c2", 32'(core_busy), 32'd0);
    chk("rd_data_c2", core_rdata, 32'hDEADBEEF); chk("rd_ren_c2", 32'(bus_ren), 32'd0);
    tick();
    core_ren = 0;
    tick();

    // Simultaneous requests: core first, extension waits.
    core_ren = 1; core_addr = 32'h10;
    ext_req_mem = 1; ext_ren = 1; ext_addr = 32'h20; ext_byte_en = 4'h3;
    bus_rdata = 32'h1111_1111;
    tick();
    @(negedge CLK); chk("sim_first_addr", bus_addr, 32'h10); chk("sim_ext_busy1", 32'(ext_busy), 32'd1);
    tick();
    core_ren = 0;
    @(negedge CLK); chk("sim_ext_busy2", 32'(ext_busy), 32'd1);
    tick();
    tick();
    @(negedge CLK); chk("sim_second_addr", bus_addr, 32'h20); chk("sim_ext_ren", 32'(bus_ren), 32'd1);
    tick();
    @(negedge CLK); chk("sim_ext_done", 32'(ext_busy), 32'd0); chk("sim_ext_rdata", ext_rdata, 32'h1111_1111);
    tick();
    ext_req_mem = 0; ext_ren = 0;
    tick();

    // Starvation bound: extension held while the core keeps requesting.
    ext_req_mem = 1; ext_ren = 1; ext_addr = 32'h20;
    core_ren = 1; core_addr = 32'h10; bus_busy = 0;
    ng = 0;
    for (int i = 0; i < 30 && ng < 8; i++) begin
      @(negedge CLK);
      if (bus_ren || bus_wen) begin
        ga[ng] = bus_addr;
        ng++;
      end
      tick();
    end
    ncore = 0;
    for (int i = 0; i < 4; i++) if (ga[i] == 32'h10) ncore++;
    chk("starve_grant_count", 32'(ng), 32'd8);
    chk("starve_core_first4", 32'(ncore), 32'd4);
    chk("starve_5th_ext", ga[4], 32'h20);
    chk("starve_6th_core", ga[5], 32'h10);
    core_ren = 0; ext_req_mem = 0; ext_ren = 0;
    repeat (4) tick();

    // Bus wait: bus_busy high for three strobe cycles.
    ext_req_mem = 1; ext_ren = 1; ext_addr = 32'h44; bus_busy = 1; bus_rdata = 32'hCAFEF00D;
    tick();
    sc = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_busy = 0;
      @(negedge CLK);
      if (bus_ren) sc++;
      tick();
    end
    @(negedge CLK);
    chk("wait_strobe_cycles", 32'(sc), 32'd4);
    chk("wait_ext_busy_low", 32'(ext_busy), 32'd0);
    chk("wait_ext_rdata", ext_rdata, 32'hCAFEF00D);
    tick();
    ext_req_mem = 0; ext_ren = 0;
    tick();

    // Abort during an extension transfer.
    ext_req_mem = 1; ext_ren = 1; ext_addr = 32'h48; bus_busy = 1; bus_rdata = 32'h12345678;
    tick();
    ext_abort = 1;
    @(negedge CLK); chk("abort_strobe1", 32'(bus_ren), 32'd1);
    tick();
    ext_abort = 0; ext_req_mem = 0; ext_ren = 0; bus_busy = 0;
    @(negedge CLK); chk("abort_strobe2", 32'(bus_ren), 32'd1);
    tick();
    @(negedge CLK); chk("abort_rdata_kept", ext_rdata, 32'hCAFEF00D); chk("abort_done_ren", 32'(bus_ren), 32'd0);
    tick();
    @(negedge CLK); chk("abort_idle_ren", 32'(bus_ren), 32'd0);
    tick();

    // Protocol error: ren and wen together becomes a write, flag is sticky.
    core_ren = 1; core_wen = 1; core_addr = 32'h40; core_wdata = 32'hA5A5A5A5;
    tick();
    @(negedge CLK);
    chk("perr_bus_wen", 32'(bus_wen), 32'd1); chk("perr_bus_ren", 32'(bus_ren), 32'd0);
    chk("perr_set", 32'(proto_err), 32'd1); chk("perr_wdata", bus_wdata, 32'hA5A5A5A5);
    tick();
    core_ren = 0; core_wen = 0;
    tick(); tick();
    @(negedge CLK); chk("perr_sticky", 32'(proto_err), 32'd1);
    tick();
    nRST = 0;
    tick();
    nRST = 1;
    @(negedge CLK); chk("perr_cleared", 32'(proto_err), 32'd0);
    tick();

    // Random traffic checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        r = int'($urandom_range(15));
        core_ren = (r < 6) || (r == 15);
        core_wen = (r >= 6 && r < 11) || (r == 15);
        core_addr = $urandom(); core_wdata = $urandom(); core_byte_en = 4'($urandom());
      end
      if ($urandom_range(3) == 0) begin
        r = int'($urandom_range(15));
        ext_req_mem = ($urandom_range(4) != 0);
        ext_ren = (r < 6) || (r == 15);
        ext_wen = (r >= 6 && r < 11) || (r == 15);
        ext_addr = $urandom(); ext_wdata = $urandom(); ext_byte_en = 4'($urandom());
      end
      ext_abort = ($urandom_range(15) == 0);
      bus_busy  = $urandom_range(1) != 0;
      bus_rdata = $urandom();
      nRST      = ($urandom_range(149) != 0);
      tick();
    end
    nRST = 1;
    tick();
    @(negedge CLK);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
